// File: rtl/haz_pkg.sv
// Shared types and defaults for the ID-stage hazard controller.
// Optional statistics counters are enabled by defining HAZ_STATS_EN.
package haz_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } haz_state_e;

  localparam int W_DEF      = 5;
  localparam int BR_LAT_DEF = 2;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID operands and ID/EX rt.
// A load into $0 never creates a dependency.
module load_use_detect #(
  parameter int W = 5
) (
  input  logic [W-1:0] id_rs,
  input  logic         id_rs_used,
  input  logic [W-1:0] id_rt,
  input  logic         id_rt_used,
  input  logic         idex_MemRead,
  input  logic [W-1:0] idex_rt,
  output logic         lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_used && (id_rs == idex_rt);
  assign rt_hit = id_rt_used && (id_rt == idex_rt);
  assign lu     = idex_MemRead && (|idex_rt)
                  && (rs_hit || rt_hit);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage stall/bubble controller for load-use and branch waits.
// Define HAZ_STATS_EN to build the stat_lu/stat_br counters.
module id_hazard_ctrl
  import haz_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int BR_LAT = BR_LAT_DEF,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  id_rs,
  input  logic          id_rs_used,
  input  logic [W-1:0]  id_rt,
  input  logic          id_rt_used,
  input  logic          id_Branch,
  input  logic          idex_MemRead,
  input  logic [W-1:0]  idex_rt,
  input  logic          exmem_Branch,
  input  logic          br_taken,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          br_err,
  output logic [CW-1:0] stat_lu,
  output logic [CW-1:0] stat_br
);

  localparam int WCW = $clog2(BR_LAT + 2);

  haz_state_e     state, state_n;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic           err_n;
  logic           lu;

  load_use_detect #(.W(W)) u_lud (
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rt        (id_rt),
    .id_rt_used   (id_rt_used),
    .idex_MemRead (idex_MemRead),
    .idex_rt      (idex_rt),
    .lu           (lu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      wcnt   <= '0;
      br_err <= 1'b0;
    end else begin
      state  <= state_n;
      wcnt   <= wcnt_n;
      br_err <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    err_n       = br_err;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (state)
      RUN: begin
        if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_Branch) begin
          state_n = BR_WAIT;
          wcnt_n  = '0;
        end
      end
      BR_WAIT: begin
        if (!exmem_Branch) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          wcnt_n      = wcnt + 1'b1;
          // Fail open so a lost strobe cannot deadlock the pipe
          if (wcnt == WCW'(BR_LAT)) begin
            err_n   = 1'b1;
            state_n = RUN;
            wcnt_n  = '0;
          end
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_n     = RUN;
        end else begin
          state_n = RUN;
        end
      end
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  logic [CW-1:0] lu_q, br_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_q <= '0;
      br_q <= '0;
    end else begin
      if (state == RUN && lu && !(&lu_q))
        lu_q <= lu_q + 1'b1;
      if (state == BR_WAIT && !(&br_q))
        br_q <= br_q + 1'b1;
    end
  end

  assign stat_lu = lu_q;
  assign stat_br = br_q;
`else
  assign stat_lu = '0;
  assign stat_br = '0;
`endif

endmodule
